// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the parametrised UART RX deserializer.
// Frame-length clamping and word alignment live here so both orders agree.
package uart_rx_pkg;

  localparam int MIN_DATA_LEN = 5;
  localparam int MAX_DATA_W   = 9;
  localparam int CNT_W        = 4;

  typedef logic [CNT_W-1:0]      cnt_t;
  typedef logic [MAX_DATA_W-1:0] word_t;

  function automatic cnt_t clamp_len(
    input logic [3:0] data_len,
    input int         w
  );
    if (data_len < cnt_t'(MIN_DATA_LEN))
      return cnt_t'(MIN_DATA_LEN);
    if (data_len > cnt_t'(w))
      return cnt_t'(w);
    return data_len;
  endfunction

  function automatic word_t len_mask(
    input cnt_t len
  );
    word_t m;
    m = '0;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (i < int'(len))
        m[i] = 1'b1;
    end
    return m;
  endfunction

  // LSB-first frames fill from the top, so they are shifted down;
  // MSB-first frames are already right-justified and only masked.
  function automatic word_t align_word(
    input word_t sh,
    input cnt_t  len,
    input logic  msb_first,
    input int    w
  );
    if (msb_first)
      return sh & len_mask(len);
    return sh >> (cnt_t'(w) - len);
  endfunction

endpackage

// File: rtl/uart_rx_deser_param.sv
// Parametrised UART RX deserializer: runtime frame length, bit order,
// running parity and a held output word with valid/ack handshake.
module uart_rx_deser_param
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int EDGE_W     = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  deser_en,
  input  logic                  sampled_bit,
  input  logic [EDGE_W-1:0]     edge_cnt,
  input  logic [EDGE_W-1:0]     sample_edge,
  input  logic [3:0]            data_len,
  input  logic                  msb_first,
  input  logic                  frame_start,
  input  logic                  frame_done,
  input  logic                  out_ack,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_calc,
  output logic                  overrun,
  output logic                  short_frame
);

  localparam int W = DATA_WIDTH;

  logic rst_meta_q;
  logic rst_sync_q;
  logic rst_n;

  logic [W-1:0] sh_q, sh_d, sh_n;
  cnt_t         cnt_q, cnt_d, cnt_n;
  logic         acc_q, acc_d, acc_n;

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         par_q, par_d;
  logic         ovr_q, ovr_d;
  logic         short_q, short_d;

  cnt_t         len_c;
  logic         strobe;
  logic         commit;
  logic [W-1:0] word_n;

  // Reset asserts at once and releases on a clock edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  assign rst_n = rst_sync_q;

  always_comb begin
    len_c  = clamp_len(data_len, W);
    strobe = deser_en
           && (edge_cnt == sample_edge)
           && (cnt_q < len_c);

    sh_n  = sh_q;
    cnt_n = cnt_q;
    acc_n = acc_q;
    if (strobe) begin
      if (msb_first)
        sh_n = {sh_q[W-2:0], sampled_bit};
      else
        sh_n = {sampled_bit, sh_q[W-1:1]};
      cnt_n = cnt_q + cnt_t'(1);
      acc_n = acc_q ^ sampled_bit;
    end

    word_n = W'(align_word(word_t'(sh_n), len_c,
                           msb_first, W));
    commit = frame_done && !frame_start
           && (cnt_n == len_c);

    sh_d    = sh_n;
    cnt_d   = cnt_n;
    acc_d   = acc_n;
    data_d  = data_q;
    valid_d = valid_q;
    par_d   = par_q;
    ovr_d   = 1'b0;
    short_d = 1'b0;

    if (frame_start) begin
      sh_d  = '0;
      cnt_d = '0;
      acc_d = 1'b0;
    end

    if (commit) begin
      data_d  = word_n;
      par_d   = acc_n;
      valid_d = 1'b1;
      ovr_d   = valid_q && !out_ack;
    end else if (out_ack && valid_q) begin
      valid_d = 1'b0;
    end

    if (frame_done && !frame_start && !commit)
      short_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      sh_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      par_q   <= 1'b0;
      ovr_q   <= 1'b0;
      short_q <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      par_q   <= par_d;
      ovr_q   <= ovr_d;
      short_q <= short_d;
    end
  end

  assign P_DATA      = data_q;
  assign data_valid  = valid_q;
  assign par_calc    = par_q;
  assign overrun     = ovr_q;
  assign short_frame = short_q;

endmodule

// File: tb/tb_uart_rx_deser_param.sv
// Directed bench for uart_rx_deser_param: a vector table of whole
// frames plus hand-written sequences for the multi-cycle corners.
module tb_uart_rx_deser_param;

  logic       CLK = 1'b0;
  logic       RST;
  logic       deser_en;
  logic       sampled_bit;
  logic [4:0] edge_cnt;
  logic [4:0] sample_edge;
  logic [3:0] data_len;
  logic       msb_first;
  logic       frame_start;
  logic       frame_done;
  logic       out_ack;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_calc;
  logic       overrun;
  logic       short_frame;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]  len;
    logic        msb;
    int          nsend;
    logic [11:0] bits;
    logic [7:0]  exp_data;
    logic        exp_par;
  } vec_t;

  vec_t vecs[10];

  uart_rx_deser_param #(
    .DATA_WIDTH(8),
    .EDGE_W(5)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .deser_en(deser_en),
    .sampled_bit(sampled_bit),
    .edge_cnt(edge_cnt),
    .sample_edge(sample_edge),
    .data_len(data_len),
    .msb_first(msb_first),
    .frame_start(frame_start),
    .frame_done(frame_done),
    .out_ack(out_ack),
    .P_DATA(P_DATA),
    .data_valid(data_valid),
    .par_calc(par_calc),
    .overrun(overrun),
    .short_frame(short_frame)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, act, exp);
    end
  endtask

  // Each bit: a disabled strobe-edge cycle, an enabled off-edge
  // cycle (both with the wrong bit), then the real strobe.
  task automatic drive_bit(input logic b);
    deser_en    = 1'b0;
    edge_cnt    = 5'd7;
    sampled_bit = ~b;
    tick();
    deser_en = 1'b1;
    edge_cnt = 5'd3;
    tick();
    edge_cnt    = 5'd7;
    sampled_bit = b;
    tick();
    deser_en = 1'b0;
    edge_cnt = 5'd0;
  endtask

  task automatic start_frame(input logic [3:0] len,
                             input logic msb);
    data_len    = len;
    msb_first   = msb;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic done_pulse();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  task automatic send_bits(input logic [11:0] bits,
                           input int n);
    for (int j = 0; j < n; j++)
      drive_bit(bits[j]);
  endtask

  task automatic send_frame(input logic [3:0] len,
                            input logic msb,
                            input logic [11:0] bits,
                            input int n);
    start_frame(len, msb);
    send_bits(bits, n);
    done_pulse();
  endtask

  task automatic ack();
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
  endtask

  initial begin
    // bits[i] is the i-th bit on the wire
    vecs[0] = '{4'd8,  1'b0, 8,  12'h04D, 8'h4D, 1'b0};
    vecs[1] = '{4'd5,  1'b0, 5,  12'h013, 8'h13, 1'b1};
    vecs[2] = '{4'd5,  1'b1, 5,  12'h013, 8'h19, 1'b1};
    vecs[3] = '{4'd7,  1'b0, 7,  12'h041, 8'h41, 1'b0};
    vecs[4] = '{4'd6,  1'b1, 6,  12'h005, 8'h28, 1'b0};
    vecs[5] = '{4'd3,  1'b0, 5,  12'h01F, 8'h1F, 1'b1};
    vecs[6] = '{4'd12, 1'b1, 8,  12'h0A5, 8'hA5, 1'b0};
    vecs[7] = '{4'd5,  1'b0, 7,  12'h075, 8'h15, 1'b1};
    vecs[8] = '{4'd8,  1'b0, 10, 12'h3FF, 8'hFF, 1'b0};
    vecs[9] = '{4'd8,  1'b1, 8,  12'h080, 8'h01, 1'b1};

    RST         = 1'b0;
    deser_en    = 1'b0;
    sampled_bit = 1'b0;
    edge_cnt    = '0;
    sample_edge = 5'd7;
    data_len    = 4'd8;
    msb_first   = 1'b0;
    frame_start = 1'b0;
    frame_done  = 1'b0;
    out_ack     = 1'b0;

    tick();
    tick();
    chk("rst_data",  32'(P_DATA), 32'h0);
    chk("rst_valid", 32'(data_valid), 32'h0);
    chk("rst_par",   32'(par_calc), 32'h0);
    chk("rst_ovr",   32'(overrun), 32'h0);
    chk("rst_short", 32'(short_frame), 32'h0);
    RST = 1'b1;
    repeat (4) tick();

    for (int i = 0; i < 10; i++) begin
      send_frame(vecs[i].len, vecs[i].msb,
                 vecs[i].bits, vecs[i].nsend);
      chk($sformatf("v%0d_data", i),
          32'(P_DATA), 32'(vecs[i].exp_data));
      chk($sformatf("v%0d_par", i),
          32'(par_calc), 32'(vecs[i].exp_par));
      chk($sformatf("v%0d_valid", i),
          32'(data_valid), 32'h1);
      chk($sformatf("v%0d_ovr", i),
          32'(overrun), 32'h0);
      chk($sformatf("v%0d_short", i),
          32'(short_frame), 32'h0);
      ack();
      chk($sformatf("v%0d_ackclr", i),
          32'(data_valid), 32'h0);
      chk($sformatf("v%0d_hold", i),
          32'(P_DATA), 32'(vecs[i].exp_data));
    end

    // overrun: second commit without ack
    send_frame(4'd8, 1'b0, 12'h04D, 8);
    chk("ovr_first_valid", 32'(data_valid), 32'h1);
    send_frame(4'd8, 1'b0, 12'h0A5, 8);
    chk("ovr_pulse", 32'(overrun), 32'h1);
    chk("ovr_data",  32'(P_DATA), 32'hA5);
    chk("ovr_valid", 32'(data_valid), 32'h1);
    tick();
    chk("ovr_one_cycle", 32'(overrun), 32'h0);
    ack();

    // ack in the commit cycle suppresses overrun
    send_frame(4'd8, 1'b0, 12'h04D, 8);
    start_frame(4'd8, 1'b0);
    send_bits(12'h0A5, 8);
    out_ack    = 1'b1;
    frame_done = 1'b1;
    tick();
    out_ack    = 1'b0;
    frame_done = 1'b0;
    chk("ackc_ovr",   32'(overrun), 32'h0);
    chk("ackc_valid", 32'(data_valid), 32'h1);
    chk("ackc_data",  32'(P_DATA), 32'hA5);
    tick();
    chk("ackc_valid2", 32'(data_valid), 32'h1);
    ack();

    // short frame keeps the held word
    send_frame(4'd8, 1'b0, 12'h05A, 8);
    start_frame(4'd8, 1'b0);
    send_bits(12'h0FF, 6);
    done_pulse();
    chk("short_pulse", 32'(short_frame), 32'h1);
    chk("short_valid", 32'(data_valid), 32'h1);
    chk("short_data",  32'(P_DATA), 32'h5A);
    chk("short_ovr",   32'(overrun), 32'h0);
    tick();
    chk("short_one_cycle", 32'(short_frame), 32'h0);
    ack();

    // last strobe coincides with frame_done
    start_frame(4'd8, 1'b0);
    send_bits(12'h0CD, 7);
    deser_en    = 1'b1;
    edge_cnt    = 5'd7;
    sampled_bit = 1'b1;
    frame_done  = 1'b1;
    tick();
    deser_en   = 1'b0;
    edge_cnt   = 5'd0;
    frame_done = 1'b0;
    chk("coin_data",  32'(P_DATA), 32'hCD);
    chk("coin_par",   32'(par_calc), 32'h1);
    chk("coin_valid", 32'(data_valid), 32'h1);
    chk("coin_short", 32'(short_frame), 32'h0);
    ack();

    // frame_start wins over same-cycle frame_done
    start_frame(4'd8, 1'b0);
    send_bits(12'h033, 8);
    frame_start = 1'b1;
    frame_done  = 1'b1;
    tick();
    frame_start = 1'b0;
    frame_done  = 1'b0;
    chk("sd_valid", 32'(data_valid), 32'h0);
    chk("sd_data",  32'(P_DATA), 32'hCD);
    chk("sd_short", 32'(short_frame), 32'h0);
    chk("sd_ovr",   32'(overrun), 32'h0);

    // reset mid-frame clears immediately
    send_frame(4'd8, 1'b0, 12'h0CD, 8);
    start_frame(4'd8, 1'b0);
    send_bits(12'h00F, 4);
    RST = 1'b0;
    #1;
    chk("mrst_data",  32'(P_DATA), 32'h0);
    chk("mrst_valid", 32'(data_valid), 32'h0);
    chk("mrst_par",   32'(par_calc), 32'h0);
    tick();
    RST = 1'b1;
    repeat (4) tick();
    send_frame(4'd8, 1'b0, 12'h0A5, 8);
    chk("post_data",  32'(P_DATA), 32'hA5);
    chk("post_par",   32'(par_calc), 32'h0);
    chk("post_valid", 32'(data_valid), 32'h1);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
